// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction-fetch slice.
package mips_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'h0000_0004;

    // Instruction addresses are word aligned; drop the byte-offset bits.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO of fetched {pc, inst} pairs between IF and ID.
// Pointers carry one extra wrap bit so full and empty are told apart
// without a separate counter.
module fetch_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]  rd_ptr_r;
    logic [AW:0]  wr_ptr_r;
    fetch_entry_t mem_r [DEPTH];
    logic         push_ok_s;
    logic         pop_ok_s;

    // Derive occupancy flags and qualified push/pop from the pointers.
    always_comb begin
        empty     = (rd_ptr_r == wr_ptr_r);
        full      = (rd_ptr_r[AW] != wr_ptr_r[AW]) &&
                    (rd_ptr_r[AW-1:0] == wr_ptr_r[AW-1:0]);
        pop_ok_s  = pop && !empty;
        // A full queue accepts a push only when the head leaves in the same cycle.
        push_ok_s = push && (!full || pop_ok_s);
        head      = mem_r[rd_ptr_r[AW-1:0]];
    end

    // Advance read/write pointers; flush or reset empties the queue.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
        end else if (flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Entry storage; cleared on reset so no stale word is ever observable.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches one word per cycle into a
// small queue and presents the queue head to ID. Redirects flush the queue,
// a syscall halt stops fetching until the next reset.
module fetch_stage
    import mips_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_b,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus_4,
    output logic        fetch_halted
);

    logic [31:0]  pc_r;
    logic         halted_r;
    logic         full_s;
    logic         empty_s;
    logic         pop_s;
    logic         fire_s;
    logic         flush_s;
    fetch_entry_t head_s;
    fetch_entry_t push_data_s;

    // Fetch/pop decisions; halt and redirect both suppress the push.
    always_comb begin
        pop_s       = !empty_s && id_ready;
        fire_s      = !halted_r && !halt && !redirect_valid && (!full_s || pop_s);
        flush_s     = halt || redirect_valid;
        push_data_s = '{pc: pc_r, inst: inst};
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst_b    (rst_b),
        .flush    (flush_s),
        .push     (fire_s),
        .push_data(push_data_s),
        .pop      (pop_s),
        .full     (full_s),
        .empty    (empty_s),
        .head     (head_s)
    );

    // PC register: frozen once halted, otherwise redirect or sequential step.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            pc_r <= RESET_PC;
        end else if (halt || halted_r) begin
            pc_r <= pc_r;
        end else if (redirect_valid) begin
            pc_r <= align_pc(redirect_pc);
        end else if (fire_s) begin
            pc_r <= pc_r + PC_STEP;
        end else begin
            pc_r <= pc_r;
        end
    end

    // Sticky halt flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            halted_r <= 1'b0;
        end else if (halt) begin
            halted_r <= 1'b1;
        end else begin
            halted_r <= halted_r;
        end
    end

    // ID-facing outputs come from registered queue state only; zero when empty.
    always_comb begin
        inst_addr    = pc_r;
        fetch_halted = halted_r;
        if_valid     = !empty_s;
        if (!empty_s) begin
            if_inst      = head_s.inst;
            if_pc        = head_s.pc;
            if_pc_plus_4 = head_s.pc + PC_STEP;
        end else begin
            if_inst      = NOP_INST;
            if_pc        = 32'h0000_0000;
            if_pc_plus_4 = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage.
module tb_fetch_stage;

    localparam logic [31:0] INST_KEY = 32'hA5A5_0000;

    logic        clk;
    logic        rst_b;
    logic [31:0] inst_addr;
    logic [31:0] inst;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus_4;
    logic        fetch_halted;

    int checks;
    int failures;

    fetch_stage #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .inst_addr     (inst_addr),
        .inst          (inst),
        .id_ready      (id_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt          (halt),
        .if_valid      (if_valid),
        .if_inst       (if_inst),
        .if_pc         (if_pc),
        .if_pc_plus_4  (if_pc_plus_4),
        .fetch_halted  (fetch_halted)
    );

    // Instruction memory model: word is a fixed function of its address.
    assign inst = inst_addr ^ INST_KEY;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_b;
        logic        id_ready;
        logic        redir;
        logic [31:0] redir_pc;
        logic        halt;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_halted;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_addr, input logic e_valid,
                             input logic [31:0] e_pc, input logic e_halted);
        logic [31:0] e_inst;
        logic [31:0] e_pc_out;
        logic [31:0] e_pc4;
        e_inst   = e_valid ? (e_pc ^ INST_KEY) : 32'h0000_0000;
        e_pc_out = e_valid ? e_pc : 32'h0000_0000;
        e_pc4    = e_valid ? (e_pc + 32'h0000_0004) : 32'h0000_0000;
        chk({tag, " inst_addr"}, inst_addr, e_addr);
        chk({tag, " if_valid"}, {31'd0, if_valid}, {31'd0, e_valid});
        chk({tag, " if_inst"}, if_inst, e_inst);
        chk({tag, " if_pc"}, if_pc, e_pc_out);
        chk({tag, " if_pc_plus_4"}, if_pc_plus_4, e_pc4);
        chk({tag, " fetch_halted"}, {31'd0, fetch_halted}, {31'd0, e_halted});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc,
                                input logic h, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep, input logic eh);
        vec_t v;
        v.rst_b = r; v.id_ready = rdy; v.redir = rv; v.redir_pc = rpc; v.halt = h;
        v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep; v.exp_halted = eh;
        return v;
    endfunction

    initial begin
        checks         = 0;
        failures       = 0;
        rst_b          = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        halt           = 1'b0;

        //          rst  rdy  rv  rpc            h    addr           v    pc             halted
        // Steady stream after reset
        vecs[0]  = mk(1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0000_0000, 1'b0, 32'h0,          1'b0);
        vecs[1]  = mk(1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0000_0004, 1'b1, 32'h0000_0000, 1'b0);
        vecs[2]  = mk(1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0000_0008, 1'b1, 32'h0000_0004, 1'b0);
        vecs[3]  = mk(1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0000_000C, 1'b1, 32'h0000_0008, 1'b0);
        vecs[4]  = mk(1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0000_0010, 1'b1, 32'h0000_000C, 1'b0);
        // ID stalls for five cycles: queue fills with 0,4 and the address holds at 8
        vecs[5]  = mk(1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0000_0000, 1'b0, 32'h0,          1'b0);
        vecs[6]  = mk(1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0000_0004, 1'b1, 32'h0000_0000, 1'b0);
        vecs[7]  = mk(1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000, 1'b0);
        vecs[8]  = mk(1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000, 1'b0);
        vecs[9]  = mk(1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000, 1'b0);
        vecs[10] = mk(1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000, 1'b0);
        // Release: ID sees 0 (this cycle), then 4, 8, 12
        vecs[11] = mk(1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0000_000C, 1'b1, 32'h0000_0004, 1'b0);
        vecs[12] = mk(1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0000_0010, 1'b1, 32'h0000_0008, 1'b0);
        vecs[13] = mk(1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0000_0014, 1'b1, 32'h0000_000C, 1'b0);
        // Full queue, then redirect to unaligned 0x42
        vecs[14] = mk(1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0000_0014, 1'b1, 32'h0000_000C, 1'b0);
        vecs[15] = mk(1'b1, 1'b0, 1'b1, 32'h0000_0042,  1'b0, 32'h0000_0040, 1'b0, 32'h0,          1'b0);
        vecs[16] = mk(1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0000_0044, 1'b1, 32'h0000_0040, 1'b0);
        // Redirect to the top word, PC wraps to zero
        vecs[17] = mk(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC,  1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0,          1'b0);
        vecs[18] = mk(1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 1'b0);
        vecs[19] = mk(1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0000_0004, 1'b1, 32'h0000_0000, 1'b0);

        step();
        for (int i = 0; i < NVEC; i++) begin
            rst_b          = vecs[i].rst_b;
            id_ready       = vecs[i].id_ready;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].redir_pc;
            halt           = vecs[i].halt;
            step();
            check_all($sformatf("v%0d", i), vecs[i].exp_addr, vecs[i].exp_valid,
                      vecs[i].exp_pc, vecs[i].exp_halted);
        end

        // Halt together with redirect on a full queue: halt wins, PC freezes.
        rst_b = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; halt = 1'b0;
        step();
        rst_b = 1'b1;
        step();
        step();
        check_all("halt_pre", 32'h0000_0008, 1'b1, 32'h0000_0000, 1'b0);
        halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        step();
        check_all("halt_edge", 32'h0000_0008, 1'b0, 32'h0, 1'b1);
        halt = 1'b0; id_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            redirect_valid = (c % 2 == 0);
            redirect_pc    = 32'h0000_0200;
            step();
            check_all($sformatf("halt_hold%0d", c), 32'h0000_0008, 1'b0, 32'h0, 1'b1);
        end
        redirect_valid = 1'b0;
        rst_b = 1'b0;
        step();
        check_all("halt_reset", 32'h0000_0000, 1'b0, 32'h0, 1'b0);
        rst_b = 1'b1;
        step();
        check_all("halt_restart", 32'h0000_0004, 1'b1, 32'h0000_0000, 1'b0);

        // Reset while full with ID ready: stale entries 0x200/0x204 must vanish.
        id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        check_all("rst_full_pre", 32'h0000_0208, 1'b1, 32'h0000_0200, 1'b0);
        rst_b = 1'b0; id_ready = 1'b1;
        step();
        check_all("rst_full_edge", 32'h0000_0000, 1'b0, 32'h0, 1'b0);
        rst_b = 1'b1;
        step();
        check_all("rst_full_next", 32'h0000_0004, 1'b1, 32'h0000_0000, 1'b0);
        step();
        check_all("rst_full_next2", 32'h0000_0008, 1'b1, 32'h0000_0004, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
